bool_event_logger: RTL and testbench

Multi-channel successor to the single-bit boolean run-length logger. Samples an N-bit boolean bus, measures how many clock cycles each bus value is held, and pushes one entry per run into an on-chip FIFO of configurable (non-power-of-two allowed) depth. Software or a downstream AXI-slave wrapper drains entries over a valid/ready port. The block adds overflow accounting, run-length saturation splitting and a synchronous clear, none of which the single-bit logger has.

---
 rtl/bool_logger_pkg.sv | 38 +++
 rtl/bool_logger_fifo.sv | 84 ++++++++
 rtl/bool_event_logger.sv | 152 +++++++++++++++
 tb/tb_bool_event_logger.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bool_logger_pkg.sv
// Shared definitions for bool_event_logger.
//
// Entry layout, MSB to LSB: {sat, value[NumChannels-1:0], length[CountWidth-1:0] [, timestamp]}.
// When BOOL_LOGGER_TIMESTAMP_EN is defined, a 32-bit timestamp occupies the LSBs of every
// entry and all other fields move up by 32 bits. Otherwise no timestamp field exists.
package bool_logger_pkg;

  localparam int unsigned DropCountWidth = 16;

`ifdef BOOL_LOGGER_TIMESTAMP_EN
  localparam int unsigned TsWidth = 32;
`else
  localparam int unsigned TsWidth = 0;
`endif

  // Total entry width.
  function automatic int unsigned entry_width(input int unsigned num_ch,
                                              input int unsigned cnt_w);
    return 1 + num_ch + cnt_w + TsWidth;
  endfunction

  // LSB of the run-length field.
  function automatic int unsigned len_lsb();
    return TsWidth;
  endfunction

  // LSB of the sampled bus value field.
  function automatic int unsigned val_lsb(input int unsigned cnt_w);
    return TsWidth + cnt_w;
  endfunction

  // Position of the saturation / continuation flag.
  function automatic int unsigned sat_bit(input int unsigned num_ch,
                                          input int unsigned cnt_w);
    return TsWidth + cnt_w + num_ch;
  endfunction

endpackage

// File: rtl/bool_logger_fifo.sv
// Show-ahead FIFO with arbitrary depth (power of two not required).
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clr_i              synchronous flush; blocks push and pop in the same cycle
//   push_i, data_i     write request and entry; accepted when not full or when popping
//   pop_i              read request; ignored while empty
//   data_o             head entry, zero while empty
//   full_o, empty_o    status flags
//   level_o            current entry count
module bool_logger_fifo #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Depth  = 12,
  parameter int unsigned LevelW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [Width-1:0]  data_i,
  input  logic              pop_i,
  output logic [Width-1:0]  data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              wr_en, rd_en;

  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign rd_en = pop_i && !empty_o && !clr_i;
  assign wr_en = push_i && (!full_o || rd_en) && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Explicit wrap so a non-power-of-two depth never indexes past the array.
      if (wr_en) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LevelW'(1);
        2'b01:   level_d = level_q - LevelW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bool_event_logger.sv
// Multi-channel boolean run-length event logger.
//
// Samples an N-bit boolean bus through a 2-flop synchroniser, measures how many cycles each
// bus value is held and queues one entry per run in a show-ahead FIFO. Runs longer than the
// counter range are split into saturated entries (sat=1 marks "run continues").
// Optional feature macro: BOOL_LOGGER_TIMESTAMP_EN appends a 32-bit free-running cycle count
// to the LSB side of each entry.
//
// Ports:
//   s00_axi_aclk, s00_axi_aresetn  clock, asynchronous active-low reset
//   data_in     asynchronous boolean bus
//   enable      arms logging; low discards the current run and blocks pushes
//   clr         synchronous clear of FIFO, run counter and overflow state
//   rd_valid, rd_ready, rd_data    drain port, head entry shown ahead
//   fill_level  entries in the FIFO
//   overflow    sticky: an entry was dropped
//   drop_count  dropped entries, saturating
module bool_event_logger
  import bool_logger_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned BufferDepth = 12,
  parameter int unsigned CountWidth  = 16
) (
  input  logic                                           s00_axi_aclk,
  input  logic                                           s00_axi_aresetn,
  input  logic [NumChannels-1:0]                         data_in,
  input  logic                                           enable,
  input  logic                                           clr,
  output logic                                           rd_valid,
  input  logic                                           rd_ready,
  output logic [entry_width(NumChannels, CountWidth)-1:0] rd_data,
  output logic [$clog2(BufferDepth+1)-1:0]               fill_level,
  output logic                                           overflow,
  output logic [DropCountWidth-1:0]                      drop_count
);

  localparam int unsigned EntryW = entry_width(NumChannels, CountWidth);
  localparam int unsigned LevelW = $clog2(BufferDepth + 1);
  localparam int unsigned LenLsb = len_lsb();
  localparam int unsigned ValLsb = val_lsb(CountWidth);
  localparam int unsigned SatBit = sat_bit(NumChannels, CountWidth);
  localparam logic [CountWidth-1:0] CntMax = {CountWidth{1'b1}};

  logic [NumChannels-1:0]    sync1_q, sync2_q;
  logic [NumChannels-1:0]    prev_q, prev_d;
  logic [CountWidth-1:0]     cnt_q, cnt_d;
  logic                      overflow_q, overflow_d;
  logic [DropCountWidth-1:0] drop_q, drop_d;

  logic                      push, push_sat;
  logic [EntryW-1:0]         entry;
  logic                      fifo_full, fifo_empty, pop_acc, drop;

  // Run detection, highest priority first: clear, disabled, value change, saturation.
  always_comb begin
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_sat = 1'b0;
    if (clr || !enable) begin
      prev_d = sync2_q;
      cnt_d  = '0;
    end else if (sync2_q != prev_q) begin
      // cnt==0 means no run is in progress (after reset, clr or disable).
      push   = (cnt_q != '0);
      prev_d = sync2_q;
      cnt_d  = CountWidth'(1);
    end else if (cnt_q == CntMax) begin
      push     = 1'b1;
      push_sat = 1'b1;
      cnt_d    = CountWidth'(1);
    end else begin
      cnt_d = cnt_q + CountWidth'(1);
    end
  end

`ifdef BOOL_LOGGER_TIMESTAMP_EN
  logic [TsWidth-1:0] ts_q;

  // Free-running; clr deliberately leaves it alone.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) ts_q <= '0;
    else                  ts_q <= ts_q + TsWidth'(1);
  end
`endif

  always_comb begin
    entry                           = '0;
    entry[SatBit]                   = push_sat;
    entry[ValLsb +: NumChannels]    = prev_q;
    entry[LenLsb +: CountWidth]     = cnt_q;
`ifdef BOOL_LOGGER_TIMESTAMP_EN
    entry[TsWidth-1:0]              = ts_q;
`endif
  end

  assign pop_acc = rd_ready && !fifo_empty && !clr;
  assign drop    = push && fifo_full && !pop_acc;

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clr) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != {DropCountWidth{1'b1}}) drop_d = drop_q + DropCountWidth'(1);
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      sync1_q    <= data_in;
      sync2_q    <= sync1_q;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  bool_logger_fifo #(
    .Width  (EntryW),
    .Depth  (BufferDepth),
    .LevelW (LevelW)
  ) u_fifo (
    .clk_i   (s00_axi_aclk),
    .rst_ni  (s00_axi_aresetn),
    .clr_i   (clr),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (rd_ready),
    .data_o  (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fill_level)
  );

  assign rd_valid   = !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_bool_event_logger.sv
// Directed bench for bool_event_logger. Two instances share clock, reset, enable and clr:
// dut_a (1 channel, 16-bit counter) and dut_b (4 channels, 4-bit counter for run splitting).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bool_event_logger;

  logic        clk = 1'b0;
  logic        rst_n, enable, clr;
  logic        data_a, ready_a, valid_a, ovf_a;
  logic [17:0] rdata_a;
  logic [3:0]  fill_a;
  logic [15:0] drop_a;
  logic [3:0]  data_b;
  logic        ready_b, valid_b, ovf_b;
  logic [8:0]  rdata_b;
  logic [3:0]  fill_b;
  logic [15:0] drop_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  bool_event_logger #(
    .NumChannels (1),
    .BufferDepth (12),
    .CountWidth  (16)
  ) dut_a (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .data_in         (data_a),
    .enable          (enable),
    .clr             (clr),
    .rd_valid        (valid_a),
    .rd_ready        (ready_a),
    .rd_data         (rdata_a),
    .fill_level      (fill_a),
    .overflow        (ovf_a),
    .drop_count      (drop_a)
  );

  bool_event_logger #(
    .NumChannels (4),
    .BufferDepth (12),
    .CountWidth  (4)
  ) dut_b (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .data_in         (data_b),
    .enable          (enable),
    .clr             (clr),
    .rd_valid        (valid_b),
    .rd_ready        (ready_b),
    .rd_data         (rdata_b),
    .fill_level      (fill_b),
    .overflow        (ovf_b),
    .drop_count      (drop_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [17:0] ent_a(input logic sat, input logic val, input logic [15:0] len);
    return {sat, val, len};
  endfunction

  function automatic logic [8:0] ent_b(input logic sat, input logic [3:0] val,
                                       input logic [3:0] len);
    return {sat, val, len};
  endfunction

  logic [17:0] exp_a;
  logic [8:0]  exp_b [4];

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    clr     = 1'b0;
    data_a  = 1'b0;
    data_b  = 4'h0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    step(2);
    check_eq("rst_valid", 64'(valid_a), 64'(0));
    check_eq("rst_fill", 64'(fill_a), 64'(0));
    check_eq("rst_data", 64'(rdata_a), 64'(0));
    check_eq("rst_ovf", 64'(ovf_a), 64'(0));
    check_eq("rst_drop", 64'(drop_a), 64'(0));

    // Low run of 5 then high run of 16 (reset released at falling edge 0).
    rst_n = 1'b1;
    step(3);
    data_a = 1'b1;
    step(2);
    check_eq("latency_not_yet", 64'(valid_a), 64'(0));
    step(1);
    check_eq("latency_valid", 64'(valid_a), 64'(1));
    check_eq("run_low5", 64'(rdata_a), 64'(ent_a(1'b0, 1'b0, 16'd5)));
    step(13);
    data_a = 1'b0;
    step(3);
    check_eq("two_runs_fill", 64'(fill_a), 64'(2));
    ready_a = 1'b1;
    step(1);
    check_eq("run_high16", 64'(rdata_a), 64'(ent_a(1'b0, 1'b1, 16'd16)));
    check_eq("pop_fill", 64'(fill_a), 64'(1));
    step(1);
    check_eq("drained_valid", 64'(valid_a), 64'(0));
    ready_a = 1'b0;

    // Overflow: 15 toggles two cycles apart into a 12-deep FIFO.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    for (int k = 0; k < 15; k++) begin
      data_a = ~data_a;
      step(2);
    end
    step(2);
    check_eq("ovf_fill", 64'(fill_a), 64'(12));
    check_eq("ovf_flag", 64'(ovf_a), 64'(1));
    check_eq("ovf_drop", 64'(drop_a), 64'(3));
    check_eq("ovf_head", 64'(rdata_a), 64'(ent_a(1'b0, 1'b0, 16'd2)));

    // Push and pop in the same cycle while full.
    data_a = 1'b0;
    step(2);
    ready_a = 1'b1;
    step(1);
    check_eq("full_pushpop_fill", 64'(fill_a), 64'(12));
    check_eq("full_pushpop_drop", 64'(drop_a), 64'(3));
    for (int i = 0; i < 12; i++) begin
      exp_a = (i < 11) ? ent_a(1'b0, 1'((i + 1) % 2), 16'd2) : ent_a(1'b0, 1'b1, 16'd4);
      check_eq($sformatf("drain_%0d", i), 64'(rdata_a), 64'(exp_a));
      step(1);
    end
    check_eq("drain_empty", 64'(valid_a), 64'(0));
    check_eq("drain_fill", 64'(fill_a), 64'(0));
    check_eq("ovf_sticky", 64'(ovf_a), 64'(1));
    ready_a = 1'b0;

    // Buffer 5 entries, then clr.
    for (int k = 0; k < 5; k++) begin
      data_a = ~data_a;
      step(2);
    end
    step(1);
    check_eq("pre_clr_fill", 64'(fill_a), 64'(5));
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check_eq("clr_fill", 64'(fill_a), 64'(0));
    check_eq("clr_valid", 64'(valid_a), 64'(0));
    check_eq("clr_ovf", 64'(ovf_a), 64'(0));
    check_eq("clr_drop", 64'(drop_a), 64'(0));
    data_a = 1'b0;
    data_b = 4'hA;
    step(3);
    check_eq("post_clr_run_a", 64'(rdata_a), 64'(ent_a(1'b0, 1'b1, 16'd2)));
    check_eq("post_clr_run_b", 64'(rdata_b), 64'(ent_b(1'b0, 4'h0, 4'd2)));

    // 40-cycle run on a 4-bit counter: 15 + 15 + 10.
    step(14);
    check_eq("sat_before", 64'(fill_b), 64'(1));
    step(1);
    check_eq("sat_first", 64'(fill_b), 64'(2));
    step(22);
    data_b = 4'h5;
    step(3);
    check_eq("sat_fill", 64'(fill_b), 64'(4));
    exp_b[0] = ent_b(1'b0, 4'h0, 4'd2);
    exp_b[1] = ent_b(1'b1, 4'hA, 4'd15);
    exp_b[2] = ent_b(1'b1, 4'hA, 4'd15);
    exp_b[3] = ent_b(1'b0, 4'hA, 4'd10);
    ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("sat_entry_%0d", i), 64'(rdata_b), 64'(exp_b[i]));
      step(1);
    end
    check_eq("sat_drained", 64'(valid_b), 64'(0));
    ready_b = 1'b0;
    data_b  = 4'h0;

    // Asynchronous reset with three entries buffered.
    data_a = 1'b1;
    step(3);
    data_a = 1'b0;
    step(3);
    check_eq("pre_rst_fill", 64'(fill_a), 64'(3));
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 64'(valid_a), 64'(0));
    check_eq("arst_fill", 64'(fill_a), 64'(0));
    check_eq("arst_data", 64'(rdata_a), 64'(0));
    check_eq("arst_valid_b", 64'(valid_b), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    check_eq("no_stale_valid", 64'(valid_a), 64'(0));
    check_eq("no_stale_fill", 64'(fill_a), 64'(0));

    // enable=0 discards activity; counting restarts once re-armed.
    enable = 1'b0;
    data_a = 1'b1;
    step(6);
    check_eq("disabled_fill", 64'(fill_a), 64'(0));
    enable = 1'b1;
    step(3);
    data_a = 1'b0;
    step(3);
    check_eq("reenable_run", 64'(rdata_a), 64'(ent_a(1'b0, 1'b1, 16'd5)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
